risk_issue: RTL and testbench

- Command-side initiator for the risk matrix coprocessor. It drives the risk_func / risk_reg / risk_addr / risk_stride_x / risk_stride_y interface that the risk responder consumes.
- Accepts commands from the CPU core over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command on the risk interface for the number of cycles that operation requires.
- Reports completion per command.

---
 rtl/risk_issue.sv | 120 ++++++++++++
 tb/tb_risk_issue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/risk_issue.sv
`default_nettype none
// ============================================================================
// Module   : risk_issue
// Brief    : Buffers CPU commands in a small FIFO and replays each one on the
//            risk interface for its operation-dependent number of cycles.
// Revision : 1.0
// ============================================================================
module risk_issue #(
    parameter int DEPTH      = 4,
    parameter int LS_CYCLES  = 2,
    parameter int ALU_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_func,
    input  logic [4:0]  cmd_reg,
    input  logic [14:0] cmd_addr,
    input  logic [13:0] cmd_stride_x,
    input  logic [13:0] cmd_stride_y,
    output logic [2:0]  risk_func,
    output logic [4:0]  risk_reg,
    output logic [14:0] risk_addr,
    output logic [13:0] risk_stride_x,
    output logic [13:0] risk_stride_y,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  issued_count
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = AW + 1;
    localparam int MAXH = (LS_CYCLES > ALU_CYCLES) ? LS_CYCLES : ALU_CYCLES;
    localparam int HW   = (MAXH > 1) ? $clog2(MAXH) : 1;
    localparam logic [HW-1:0] LS_LAST    = HW'(LS_CYCLES - 1);
    localparam logic [HW-1:0] ALU_LAST   = HW'(ALU_CYCLES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t        state;
    logic [50:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [HW-1:0] hold;

    logic          accept;
    logic          reserved;
    logic          push;
    logic          pop;
    logic [50:0]   head;
    logic          head_ls;
    logic [HW-1:0] head_last;
    logic [CW-1:0] count_next;

    assign accept     = cmd_valid && cmd_ready;
    assign reserved   = cmd_func[2] && cmd_func[1];
    assign push       = accept && !reserved && (cmd_func != 3'b000);
    // Pop only from the pre-edge contents: a command pushed into an empty FIFO waits one edge.
    assign pop        = (count != '0) && ((state == IDLE) || (hold == '0));
    assign count_next = count + CW'(push) - CW'(pop);
    assign head       = mem[rd_ptr];
    assign head_ls    = (head[50:48] == 3'b001) || (head[50:48] == 3'b010);
    assign head_last  = head_ls ? LS_LAST : ALU_LAST;
    assign busy       = (count != '0) || (state == HOLD);

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= {cmd_func, cmd_reg, cmd_addr, cmd_stride_x, cmd_stride_y};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            hold          <= '0;
            cmd_ready     <= 1'b0;
            risk_func     <= 3'b000;
            risk_reg      <= '0;
            risk_addr     <= '0;
            risk_stride_x <= '0;
            risk_stride_y <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            issued_count  <= '0;
        end else begin
            cmd_ready <= (count_next < FULL_COUNT);
            err       <= accept && reserved;
            count     <= count_next;
            done      <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if ((state == HOLD) && (hold == '0)) begin
                issued_count <= issued_count + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                {risk_func, risk_reg, risk_addr, risk_stride_x, risk_stride_y} <= head;
                hold  <= head_last;
                state <= HOLD;
                done  <= (head_last == '0);
            end else if (state == HOLD) begin
                if (hold != '0) begin
                    hold <= hold - HW'(1);
                    done <= (hold == HW'(1));
                end else begin
                    state     <= IDLE;
                    risk_func <= 3'b000;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_risk_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_risk_issue
// Brief    : Directed bench for risk_issue with a command-queue reference model.
// Revision : 1.0
// ============================================================================
module tb_risk_issue;
    localparam int DEPTH = 4;
    localparam int LS    = 2;
    localparam int ALU   = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_func = '0;
    logic [4:0]  cmd_reg = '0;
    logic [14:0] cmd_addr = '0;
    logic [13:0] cmd_stride_x = '0;
    logic [13:0] cmd_stride_y = '0;
    logic [2:0]  risk_func;
    logic [4:0]  risk_reg;
    logic [14:0] risk_addr;
    logic [13:0] risk_stride_x;
    logic [13:0] risk_stride_y;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  issued_count;

    risk_issue #(.DEPTH(DEPTH), .LS_CYCLES(LS), .ALU_CYCLES(ALU)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_func(cmd_func), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
        .cmd_stride_x(cmd_stride_x), .cmd_stride_y(cmd_stride_y),
        .risk_func(risk_func), .risk_reg(risk_reg), .risk_addr(risk_addr),
        .risk_stride_x(risk_stride_x), .risk_stride_y(risk_stride_y),
        .busy(busy), .done(done), .err(err), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending commands plus the command on the bus
    // with the number of bus cycles it still has to be held.
    logic [50:0] m_q[$];
    logic [50:0] m_c;
    bit          m_init = 0;
    bit          m_acc;
    bit          m_active;
    int          m_left;
    logic [50:0] m_bus;
    logic        m_ready, m_done, m_err, m_busy;
    logic [7:0]  m_issued;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_active = 0; m_left = 0; m_bus = '0;
            m_ready = 0; m_done = 0; m_err = 0; m_busy = 0; m_issued = '0;
            m_init = 1;
        end else if (m_init) begin
            m_acc = cmd_valid && m_ready;
            m_err = m_acc && (cmd_func >= 3'd6);
            if (m_active && m_left == 1) m_issued = m_issued + 8'd1;
            if (m_active) begin
                m_left--;
                if (m_left == 0) m_active = 0;
            end
            if (!m_active && m_q.size() > 0) begin
                m_c = m_q.pop_front();
                m_bus = m_c;
                m_left = (m_c[50:48] == 3'd1 || m_c[50:48] == 3'd2) ? LS : ALU;
                m_active = 1;
            end else if (!m_active) begin
                m_bus[50:48] = 3'b000;
            end
            if (m_acc && cmd_func != 3'd0 && cmd_func < 3'd6)
                m_q.push_back({cmd_func, cmd_reg, cmd_addr, cmd_stride_x, cmd_stride_y});
            m_ready = (m_q.size() < DEPTH);
            m_done  = m_active && (m_left == 1);
            m_busy  = (m_q.size() != 0) || m_active;
        end
    end

    // Per-cycle comparison plus event statistics used by the literal checks.
    int n_active, n_done, n_err, n_fall, n_rise, n_notready;
    logic [2:0]  f_log[$];
    logic [14:0] a_log[$];
    logic prev_done = 0;
    logic [2:0] prev_func = '0;

    always @(negedge clk) begin
        if (m_init) begin
            check("cmd_ready", 32'(cmd_ready), 32'(m_ready));
            check("risk_func", 32'(risk_func), 32'(m_bus[50:48]));
            check("risk_reg", 32'(risk_reg), 32'(m_bus[47:43]));
            check("risk_addr", 32'(risk_addr), 32'(m_bus[42:28]));
            check("risk_stride_x", 32'(risk_stride_x), 32'(m_bus[27:14]));
            check("risk_stride_y", 32'(risk_stride_y), 32'(m_bus[13:0]));
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("err", 32'(err), 32'(m_err));
            check("issued_count", 32'(issued_count), 32'(m_issued));
            if (risk_func != 3'd0) begin
                n_active++;
                f_log.push_back(risk_func);
                a_log.push_back(risk_addr);
            end
            if (risk_func == 3'd0 && prev_func != 3'd0) n_fall++;
            if (done && !prev_done) n_rise++;
            if (done) n_done++;
            if (err) n_err++;
            if (!cmd_ready && !reset) n_notready++;
            prev_done = done;
            prev_func = risk_func;
        end
    end

    task automatic clr_stats();
        n_active = 0; n_done = 0; n_err = 0; n_fall = 0; n_rise = 0; n_notready = 0;
        f_log.delete(); a_log.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
        tick();
    endtask

    task automatic send(input logic [2:0] f, input logic [4:0] r, input logic [14:0] a,
                        input logic [13:0] sx, input logic [13:0] sy);
        logic rdy;
        int g = 0;
        cmd_valid = 1; cmd_func = f; cmd_reg = r; cmd_addr = a;
        cmd_stride_x = sx; cmd_stride_y = sy;
        do begin
            @(negedge clk);
            rdy = cmd_ready;
            tick();
            g++;
        end while (!rdy && g < 200);
        cmd_valid = 0;
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy !== 1'b0 && g < 2000) begin
            tick();
            g++;
        end
        tick(); tick();
        if (g >= 2000) begin
            checks++; errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    initial begin
        logic [2:0] seq2 [4];
        do_reset();
        check("reset_risk_func", 32'(risk_func), 32'd0);
        check("reset_ready", 32'(cmd_ready), 32'd1);
        check("reset_issued", 32'(issued_count), 32'd0);

        // 1: single load
        clr_stats();
        send(3'b010, 5'd0, 15'd0, 14'd3, 14'd3);
        check("t1_latency_func", 32'(risk_func), 32'd0);
        tick();
        check("t1_first_func", 32'(risk_func), 32'd2);
        check("t1_stride_y", 32'(risk_stride_y), 32'd3);
        wait_idle();
        check("t1_active_cycles", n_active, 32'd2);
        check("t1_done_pulses", n_done, 32'd1);
        check("t1_issued", 32'(issued_count), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);

        // 2: load then store back to back
        do_reset(); clr_stats();
        send(3'b010, 5'd1, 15'd0, 14'd1, 14'd1);
        send(3'b001, 5'd2, 15'h10, 14'd1, 14'd1);
        wait_idle();
        seq2[0] = 3'b010; seq2[1] = 3'b010; seq2[2] = 3'b001; seq2[3] = 3'b001;
        check("t2_len", f_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < f_log.size(); i++) check("t2_seq", 32'(f_log[i]), 32'(seq2[i]));
        check("t2_gaps", n_fall, 32'd1);
        check("t2_done", n_done, 32'd2);
        check("t2_issued", 32'(issued_count), 32'd2);

        // 3: eight loads with valid held continuously
        do_reset(); clr_stats();
        for (int i = 0; i < 8; i++) send(3'b010, 5'd0, 15'(i), 14'd0, 14'd0);
        wait_idle();
        check("t3_ready_dropped", 32'(n_notready > 0), 32'd1);
        check("t3_len", a_log.size(), 32'd16);
        for (int i = 0; i < 16 && i < a_log.size(); i++) check("t3_addr", 32'(a_log[i]), 32'(i / 2));
        check("t3_issued", 32'(issued_count), 32'd8);

        // 4: reserved, nop, matmul
        do_reset(); clr_stats();
        send(3'b110, 5'd0, 15'd1, 14'd0, 14'd0);
        send(3'b000, 5'd0, 15'd2, 14'd0, 14'd0);
        send(3'b011, 5'd4, 15'd5, 14'd0, 14'd0);
        wait_idle();
        check("t4_err", n_err, 32'd1);
        check("t4_active", n_active, 32'd1);
        check("t4_addr", a_log.size() > 0 ? 32'(a_log[0]) : 32'hFFFF, 32'd5);
        check("t4_issued", 32'(issued_count), 32'd1);

        // 5: reset during the first hold cycle of a load with more loads queued
        do_reset(); clr_stats();
        cmd_valid = 1; cmd_func = 3'b010; cmd_addr = 15'd1;
        tick();
        cmd_addr = 15'd2;
        tick();
        cmd_addr = 15'd3; reset = 1;
        tick();
        reset = 0; cmd_valid = 0;
        check("t5_func_after_reset", 32'(risk_func), 32'd0);
        check("t5_busy_after_reset", 32'(busy), 32'd0);
        n_active = 0;
        repeat (8) tick();
        check("t5_issued", 32'(issued_count), 32'd0);
        check("t5_ready", 32'(cmd_ready), 32'd1);
        check("t5_no_activity", n_active, 32'd0);
        check("t5_no_done", n_done, 32'd0);
        check("t5_no_err", n_err, 32'd0);

        // 6: 256 adds wrap issued_count
        do_reset(); clr_stats();
        for (int i = 0; i < 256; i++) send(3'b100, 5'(i), 15'(i), 14'(i), 14'(i));
        wait_idle();
        check("t6_done", n_done, 32'd256);
        check("t6_done_runs", n_rise, 32'd1);
        check("t6_active", n_active, 32'd256);
        check("t6_issued", 32'(issued_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
